// File: rtl/video_out.sv
// video_out: VGA raster counters, palette index pass-through and registered colour/sync pins.
// Optional feature macro VIDEO_SCANLINE_EN: halves colour on odd lines while scanline is high.
module video_out #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       new_line,
    output logic       new_frame,
    input  logic [5:0] pix_idx,
    output logic [5:0] palidx,
    input  logic [3:0] pal_r,
    input  logic [3:0] pal_g,
    input  logic [3:0] pal_b,
    input  logic       scanline,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DE_END   = 10'(H_ACTIVE);
    localparam logic [9:0] V_DE_END   = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic de_p0, hs_p0, vs_p0;
    logic de_p1, hs_p1, vs_p1, odd_p1;
    logic dim_p1;

    // Halve one colour channel for the scanline effect.
    function automatic logic [3:0] shade(input logic [3:0] c, input logic dim);
        return dim ? (c >> 1) : c;
    endfunction

    // Stage 0: raster counters and position decode
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (hpos == H_LAST) begin
            hpos <= '0;
            vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    assign new_line  = (hpos == 10'd0);
    assign new_frame = new_line && (vpos == 10'd0);
    assign de_p0     = (hpos < H_DE_END) && (vpos < V_DE_END);
    assign hs_p0     = (hpos >= H_SYNC_BEG) && (hpos < H_SYNC_END);
    assign vs_p0     = (vpos >= V_SYNC_BEG) && (vpos < V_SYNC_END);

    // Stage 1: timing registered; palette lookup happens combinationally this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            de_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            odd_p1 <= 1'b0;
        end else begin
            de_p1  <= de_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            odd_p1 <= vpos[0];
        end
    end

    assign palidx = pix_idx;

`ifdef VIDEO_SCANLINE_EN
    assign dim_p1 = scanline && odd_p1;
`else
    logic cfg_unused;
    assign dim_p1     = 1'b0;
    assign cfg_unused = scanline ^ odd_p1;
`endif

    // Stage 2: pins; colour forced to black outside the active area
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r     <= 4'd0;
            vga_g     <= 4'd0;
            vga_b     <= 4'd0;
            vga_de    <= 1'b0;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
        end else begin
            vga_r     <= de_p1 ? shade(pal_r, dim_p1) : 4'd0;
            vga_g     <= de_p1 ? shade(pal_g, dim_p1) : 4'd0;
            vga_b     <= de_p1 ? shade(pal_b, dim_p1) : 4'd0;
            vga_de    <= de_p1;
            vga_hsync <= hs_p1 ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync <= vs_p1 ? VSYNC_POL : ~VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_video_out.sv
// Self-checking bench for video_out on a shrunken raster, against a cycle-count position model.
module tb_video_out;

    localparam int HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
`ifdef VIDEO_SCANLINE_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos, vpos;
    logic       new_line, new_frame;
    logic [5:0] pix_idx = '0;
    logic [5:0] palidx;
    logic [3:0] pal_r, pal_g, pal_b;
    logic       scanline = 1'b0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync, vga_de;

    logic [11:0] pal_mem [64];

    int errors = 0;
    int checks = 0;
    int t = 0;
    int rst_cnt = 0;
    int scan_mode = 0;
    logic [5:0] pix_prev = '0;
    logic       scan_prev = 1'b0;

    always #5 clk = ~clk;

    always_comb {pal_r, pal_g, pal_b} = pal_mem[palidx];

    video_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .hpos(hpos), .vpos(vpos), .new_line(new_line), .new_frame(new_frame),
        .pix_idx(pix_idx), .palidx(palidx),
        .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .scanline(scanline),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge.
    task automatic step(input logic rst_v);
        int p, h, v, er, eg, eb;
        logic [11:0] c;
        logic ede;
        @(posedge clk);
        #1;
        pix_prev  = pix_idx;
        scan_prev = scanline;
        reset     = rst_v;
        pix_idx   = (t == 1 || $urandom_range(1) == 1) ? 6'd5 : 6'($urandom_range(63));
        scanline  = (scan_mode == 0) ? 1'b0 : (scan_mode == 1) ? 1'b1 : 1'($urandom_range(1));
        @(negedge clk);
        if (rst_v) begin
            rst_cnt++;
            t = 0;
            if (rst_cnt >= 2) begin
                check("rst_hpos", 32'(hpos), 0);
                check("rst_vpos", 32'(vpos), 0);
                check("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 0);
                check("rst_de", 32'(vga_de), 0);
                check("rst_hsync", 32'(vga_hsync), 1);
                check("rst_vsync", 32'(vga_vsync), 1);
            end
        end else begin
            rst_cnt = 0;
            check("hpos", 32'(hpos), t % HT);
            check("vpos", 32'(vpos), (t / HT) % VT);
            check("new_line", 32'(new_line), 32'((t % HT) == 0));
            check("new_frame", 32'(new_frame), 32'((t % (HT * VT)) == 0));
            check("palidx", 32'(palidx), 32'(pix_idx));
            if (t < 2) begin
                er = 0; eg = 0; eb = 0; ede = 1'b0; h = HA; v = 0;
            end else begin
                p   = t - 2;
                h   = p % HT;
                v   = (p / HT) % VT;
                ede = (h < HA) && (v < VA);
                c   = pal_mem[pix_prev];
                er  = ede ? int'(c[11:8]) : 0;
                eg  = ede ? int'(c[7:4])  : 0;
                eb  = ede ? int'(c[3:0])  : 0;
                if (SCAN_EN && scan_prev && (v % 2 == 1)) begin
                    er = er / 2; eg = eg / 2; eb = eb / 2;
                end
            end
            check("vga_r", 32'(vga_r), er);
            check("vga_g", 32'(vga_g), eg);
            check("vga_b", 32'(vga_b), eb);
            check("vga_de", 32'(vga_de), 32'(ede));
            check("vga_hsync", 32'(vga_hsync),
                  (t >= 2 && h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
            check("vga_vsync", 32'(vga_vsync),
                  (t >= 2 && v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
            t++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pal_mem[i] = 12'($urandom);
        pal_mem[5] = 12'hF1F;

        scan_mode = 0;
        repeat (3) step(1'b1);
        repeat (HT * VT + 5 * HT + 30) step(1'b0);

        // Mid-frame reset, then scanline held high across odd and even lines.
        scan_mode = 1;
        repeat (3) step(1'b1);
        repeat (2 * HT * VT + 10) step(1'b0);

        scan_mode = 2;
        repeat (2) step(1'b1);
        repeat (HT * VT + 3) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
